// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: sizes a request into byte enables, drives the
// byte-addressed bus until ready or timeout, and returns lane-extracted load data.
module mem_access_unit #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic                iClk,
   input  logic                nRst,
   input  logic                iReq,
   input  logic                iWrite,
   input  logic [1:0]          iSize,
   input  logic                iSigned,
   input  logic [ADDR_W-1:0]   iAddr,
   input  logic [DATA_W-1:0]   iWData,
   output logic                oBusy,
   output logic                oDone,
   output logic [1:0]          oErr,
   output logic [DATA_W-1:0]   oRData,
   output logic [ADDR_W-1:0]   oMemAddr,
   output logic [DATA_W-1:0]   oMemData,
   output logic [DATA_W/8-1:0] oMemBE,
   output logic                oMemRead,
   output logic                oMemWrite,
   input  logic [DATA_W-1:0]   iMemData,
   input  logic                iMemRdy
);

   localparam int LANES = DATA_W / 8;
   localparam int LSB_W = $clog2(LANES);
   localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t              r_state, w_next;
   logic [TO_W-1:0]     r_cnt;
   logic                r_write, r_signed;
   logic [1:0]          r_size;
   logic [LSB_W-1:0]    r_lane;
   logic [1:0]          r_err;
   logic [DATA_W-1:0]   r_rdata, r_memdata;
   logic [ADDR_W-1:0]   r_memaddr;
   logic [LANES-1:0]    r_membe;

   int                  w_nb, w_lane_in, w_nb_r;
   logic                w_misalign, w_timeout, w_sbit;
   logic [LANES-1:0]    w_be;
   logic [DATA_W-1:0]   w_wrep, w_shift, w_mask, w_load;

   // Request decode straight from the inputs, used only on the accept edge
   always_comb begin
      w_nb       = 1 << iSize;
      w_lane_in  = int'(iAddr[LSB_W-1:0]);
      w_misalign = (w_nb > LANES) || ((w_lane_in % w_nb) != 0);
      w_be       = '0;
      w_wrep     = '0;
      for (int i = 0; i < LANES; i++) begin
         w_be[i]          = (i >= w_lane_in) && (i < w_lane_in + w_nb);
         w_wrep[8*i +: 8] = iWData[8*(i % w_nb) +: 8];
      end
   end

   // Lane extraction; the mask covers the access width, the rest is sign or zero fill
   always_comb begin
      w_shift = iMemData >> {r_lane, 3'b000};
      w_nb_r  = 1 << r_size;
      if (w_nb_r > LANES) w_nb_r = LANES;
      w_mask  = '0;
      for (int i = 0; i < LANES; i++)
         w_mask[8*i +: 8] = (i < w_nb_r) ? 8'hFF : 8'h00;
      w_sbit  = r_signed && w_shift[8*w_nb_r - 1];
      w_load  = (w_shift & w_mask) | (w_sbit ? ~w_mask : '0);
   end

   assign w_timeout = (TIMEOUT > 0) && (r_cnt == TO_LAST);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (iReq) w_next = w_misalign ? S_RESP : S_ACCESS;
         S_ACCESS: if (iMemRdy || w_timeout) w_next = S_RESP;
         S_RESP:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (!nRst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_write   <= 1'b0;
         r_signed  <= 1'b0;
         r_size    <= '0;
         r_lane    <= '0;
         r_err     <= '0;
         r_rdata   <= '0;
         r_memdata <= '0;
         r_memaddr <= '0;
         r_membe   <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: if (iReq) begin
               r_write  <= iWrite;
               r_size   <= iSize;
               r_signed <= iSigned;
               r_lane   <= iAddr[LSB_W-1:0];
               r_cnt    <= '0;
               r_err    <= w_misalign ? 2'b01 : 2'b00;
               if (!w_misalign) begin
                  r_memaddr <= {iAddr[ADDR_W-1:LSB_W], {LSB_W{1'b0}}};
                  r_membe   <= w_be;
                  r_memdata <= w_wrep;
               end
            end
            S_ACCESS: begin
               if (iMemRdy) begin
                  r_err <= 2'b00;
                  if (!r_write) r_rdata <= w_load;
               end else if (w_timeout) begin
                  r_err <= 2'b10;
               end else if (TIMEOUT > 0) begin
                  r_cnt <= r_cnt + TO_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign oBusy     = (r_state != S_IDLE);
   assign oDone     = (r_state == S_RESP);
   assign oErr      = (r_state == S_RESP) ? r_err : 2'b00;
   assign oRData    = r_rdata;
   assign oMemAddr  = r_memaddr;
   assign oMemData  = r_memdata;
   assign oMemBE    = r_membe;
   assign oMemRead  = (r_state == S_ACCESS) && !r_write;
   assign oMemWrite = (r_state == S_ACCESS) && r_write;

endmodule
